// File: rtl/gcd_controlpath.sv
// Moore controller for the 16-bit repeated-subtraction GCD datapath.
// Adds a start/busy/done handshake, a subtraction counter and a runaway timeout.
module gcd_controlpath #(
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_gt,
    input  logic             i_lt,
    input  logic             i_eq,
    output logic             o_LdA,
    output logic             o_LdB,
    output logic             o_sel1,
    output logic             o_sel2,
    output logic             o_sel_in,
    output logic             o_in_req_a,
    output logic             o_in_req_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [CNT_W-1:0] o_iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_CMP,
        S_SUB_A,
        S_SUB_B,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [CNT_W-1:0] LP_MAX_ITER = CNT_W'(MAX_ITER);

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_iterCnt;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_nextState = S_LOAD_A;
            S_LOAD_A: w_nextState = S_LOAD_B;
            S_LOAD_B: w_nextState = S_CMP;
            S_CMP: begin
                // Equality wins over the limit so a run converging on its last allowed step still completes.
                if (i_eq)                         w_nextState = S_DONE;
                else if (r_iterCnt == LP_MAX_ITER) w_nextState = S_ERR;
                else if (i_gt)                    w_nextState = S_SUB_A;
                else if (i_lt)                    w_nextState = S_SUB_B;
                else                              w_nextState = S_ERR;
            end
            S_SUB_A:  w_nextState = S_CMP;
            S_SUB_B:  w_nextState = S_CMP;
            S_DONE:   if (i_start) w_nextState = S_LOAD_A;
            S_ERR:    if (i_start) w_nextState = S_LOAD_A;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they always equal a decode of r_state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_iterCnt  <= '0;
            o_LdA      <= 1'b0;
            o_LdB      <= 1'b0;
            o_sel1     <= 1'b0;
            o_sel2     <= 1'b0;
            o_sel_in   <= 1'b0;
            o_in_req_a <= 1'b0;
            o_in_req_b <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            o_LdA      <= (w_nextState == S_LOAD_A) || (w_nextState == S_SUB_A);
            o_LdB      <= (w_nextState == S_LOAD_B) || (w_nextState == S_SUB_B);
            o_sel1     <= (w_nextState == S_SUB_B);
            o_sel2     <= (w_nextState == S_SUB_A);
            o_sel_in   <= (w_nextState == S_LOAD_A) || (w_nextState == S_LOAD_B);
            o_in_req_a <= (w_nextState == S_LOAD_A);
            o_in_req_b <= (w_nextState == S_LOAD_B);
            o_busy     <= (w_nextState == S_LOAD_A) || (w_nextState == S_LOAD_B) ||
                          (w_nextState == S_CMP)    || (w_nextState == S_SUB_A)  ||
                          (w_nextState == S_SUB_B);
            o_done     <= (w_nextState == S_DONE);
            o_error    <= (w_nextState == S_ERR);
            if (r_state == S_LOAD_A) begin
                r_iterCnt <= '0;
            end else if (((r_state == S_SUB_A) || (r_state == S_SUB_B)) &&
                         (r_iterCnt != LP_MAX_ITER)) begin
                r_iterCnt <= r_iterCnt + CNT_W'(1);
            end
        end
    end

    assign o_iter_cnt = r_iterCnt;

endmodule

// File: tb/tb_gcd_controlpath.sv
// Bench for gcd_controlpath: a behavioural A/B datapath closes the loop, a scoreboard
// queue holds expected results and a monitor checks each completion as it appears.
module tb_gcd_controlpath;

    localparam int CNT_W    = 16;
    localparam int MAX_ITER = 12;

    typedef struct {
        logic        expDone;
        logic        expErr;
        logic [15:0] expIter;
        logic [15:0] expA;
        logic        checkA;
        int          expLat;
        int          startCycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic gt, lt, eq;
    logic LdA, LdB, sel1, sel2, sel_in, in_req_a, in_req_b, busy, done, error;
    logic [CNT_W-1:0] iterCnt;

    logic [15:0] regA = 16'd0;
    logic [15:0] regB = 16'd0;
    logic [15:0] opA = 16'd0;
    logic [15:0] opB = 16'd0;
    logic [15:0] dataIn, busX, busY, bus;

    int   cycleCnt = 0;
    int   testsRun = 0;
    int   testsFailed = 0;
    logic prevFinished = 1'b0;
    exp_t sb[$];

    gcd_controlpath #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_gt(gt), .i_lt(lt), .i_eq(eq),
        .o_LdA(LdA), .o_LdB(LdB), .o_sel1(sel1), .o_sel2(sel2), .o_sel_in(sel_in),
        .o_in_req_a(in_req_a), .o_in_req_b(in_req_b),
        .o_busy(busy), .o_done(done), .o_error(error), .o_iter_cnt(iterCnt)
    );

    always #5 clk = ~clk;

    // Datapath model: muxes, subtractor, comparator and the two operand registers.
    assign dataIn = in_req_a ? opA : (in_req_b ? opB : 16'd0);
    assign busX   = sel1 ? regB : regA;
    assign busY   = sel2 ? regB : regA;
    assign bus    = sel_in ? dataIn : (busX - busY);
    assign gt     = (regA > regB);
    assign lt     = (regA < regB);
    assign eq     = (regA == regB);

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (LdA) regA <= bus;
        if (LdB) regB <= bus;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: load-enable exclusivity every cycle, scoreboard pop on each new completion.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checkOutput("ld_exclusive", int'(LdA && LdB), 0);
            if ((done || error) && !prevFinished) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_completion", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done", int'(done), int'(e.expDone));
                    checkOutput("error", int'(error), int'(e.expErr));
                    checkOutput("iter_cnt", int'(iterCnt), int'(e.expIter));
                    checkOutput("latency", cycleCnt - e.startCycle, e.expLat);
                    checkOutput("busy_at_end", int'(busy), 0);
                    if (e.checkA) begin
                        checkOutput("result_A", int'(regA), int'(e.expA));
                        checkOutput("result_B", int'(regB), int'(e.expA));
                    end
                end
            end
            prevFinished <= done || error;
        end else begin
            prevFinished <= 1'b0;
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic expDone, input logic expErr,
                                 input int expIter, input int expA, input logic checkA,
                                 input int expLat, input logic noisy);
        exp_t e;
        int   waited;
        @(negedge clk);
        opA   = a;
        opB   = b;
        start = 1'b1;
        e.expDone    = expDone;
        e.expErr     = expErr;
        e.expIter    = 16'(expIter);
        e.expA       = 16'(expA);
        e.checkA     = checkA;
        e.expLat     = expLat;
        e.startCycle = cycleCnt;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        checkOutput("launch_in_req_a", int'(in_req_a), 1);
        checkOutput("launch_LdA", int'(LdA), 1);
        checkOutput("launch_sel_in", int'(sel_in), 1);
        checkOutput("launch_busy", int'(busy), 1);
        checkOutput("launch_done", int'(done), 0);
        if (noisy) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            checkOutput("completion_timeout", waited, 0);
            void'(sb.pop_front());
        end
    endtask

    task automatic resetMidRun();
        int waited;
        @(negedge clk);
        opA   = 16'd143;
        opB   = 16'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!(LdA && !sel_in && iterCnt == 16'd3) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reach_sub_a", int'(LdA && !sel_in), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_LdA_drop", int'(LdA), 0);
        checkOutput("rst_outputs",
                    int'({LdA, LdB, sel1, sel2, sel_in, in_req_a, in_req_b, busy, done, error}), 0);
        checkOutput("rst_iter_cnt", int'(iterCnt), 0);
        @(negedge clk);
        checkOutput("rst_hold_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_idle", int'(busy | done | error), 0);
    endtask

    initial begin
        #12;
        checkOutput("reset_outputs",
                    int'({LdA, LdB, sel1, sel2, sel_in, in_req_a, in_req_b, busy, done, error}), 0);
        checkOutput("reset_iter_cnt", int'(iterCnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_no_start", int'(busy), 0);

        // a, b, done, error, iter, A, checkA, latency, start-noise
        applyStimulus(16'd12,  16'd8,  1'b1, 1'b0, 2,  4,  1'b1, 8,  1'b1);
        applyStimulus(16'd7,   16'd7,  1'b1, 1'b0, 0,  7,  1'b1, 4,  1'b0);
        applyStimulus(16'd143, 16'd13, 1'b1, 1'b0, 10, 13, 1'b1, 24, 1'b0);
        applyStimulus(16'd9,   16'd15, 1'b1, 1'b0, 3,  3,  1'b1, 10, 1'b0);
        applyStimulus(16'd169, 16'd13, 1'b1, 1'b0, 12, 13, 1'b1, 28, 1'b0);
        applyStimulus(16'd182, 16'd13, 1'b0, 1'b1, 12, 0,  1'b0, 28, 1'b0);
        applyStimulus(16'd0,   16'd5,  1'b0, 1'b1, 12, 0,  1'b0, 28, 1'b0);
        applyStimulus(16'd0,   16'd0,  1'b1, 1'b0, 0,  0,  1'b1, 4,  1'b0);

        resetMidRun();
        applyStimulus(16'd12,  16'd8,  1'b1, 1'b0, 2,  4,  1'b1, 8,  1'b0);

        repeat (3) @(negedge clk);
        checkOutput("done_holds", int'(done), 1);
        checkOutput("iter_holds", int'(iterCnt), 2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
